// File: rtl/writeback_unit_if.sv
// Execution-result inputs and register-unit writeback outputs of writeback_unit.
// master = result producer / register-unit side, slave = writeback_unit.
interface writeback_unit_if #(
  parameter int addressSize  = 64,
  parameter int regWidth     = 5,
  parameter int fifoPtrWidth = 3
);
  logic                    ex1Enable_i;
  logic [regWidth-1:0]     ex1Address_i;
  logic [addressSize-1:0]  ex1Data_i;
  logic                    ex2Enable_i;
  logic [regWidth-1:0]     ex2Address_i;
  logic [addressSize-1:0]  ex2Data_i;
  logic                    stall_o;
  logic                    overflow_o;
  logic [fifoPtrWidth:0]   occupancy_o;
  logic                    reg1isWriteback_o;
  logic [regWidth-1:0]     reg1WritebackAddress_o;
  logic [addressSize-1:0]  reg1WritebackData_o;
  logic                    reg2isWriteback_o;
  logic [regWidth-1:0]     reg2WritebackAddress_o;
  logic [addressSize-1:0]  reg2WritebackData_o;

  modport master (
    output ex1Enable_i, ex1Address_i, ex1Data_i,
    output ex2Enable_i, ex2Address_i, ex2Data_i,
    input  stall_o, overflow_o, occupancy_o,
    input  reg1isWriteback_o, reg1WritebackAddress_o, reg1WritebackData_o,
    input  reg2isWriteback_o, reg2WritebackAddress_o, reg2WritebackData_o
  );

  modport slave (
    input  ex1Enable_i, ex1Address_i, ex1Data_i,
    input  ex2Enable_i, ex2Address_i, ex2Data_i,
    output stall_o, overflow_o, occupancy_o,
    output reg1isWriteback_o, reg1WritebackAddress_o, reg1WritebackData_o,
    output reg2isWriteback_o, reg2WritebackAddress_o, reg2WritebackData_o
  );
endinterface

// File: rtl/writeback_unit.sv
// In-order result FIFO draining up to two writebacks per cycle; result visible one edge after push.
// Pushes beyond capacity are dropped (sticky overflow_o); stall_o warns upstream with two slots still free.
module writeback_unit #(
  parameter int addressSize  = 64,
  parameter int regWidth     = 5,
  parameter int fifoDepth    = 8,
  parameter int fifoPtrWidth = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  writeback_unit_if.slave  wb
);
  localparam int CW = fifoPtrWidth + 1;
  typedef logic [fifoPtrWidth-1:0] ptr_t;
  typedef logic [CW-1:0]           cnt_t;

  logic [regWidth-1:0]    addr_mem [fifoDepth];
  logic [addressSize-1:0] data_mem [fifoDepth];

  ptr_t head_q, head_d, tail_q, tail_d, head_nxt, wr2_ptr;
  cnt_t count_q, count_d;
  logic overflow_q, overflow_d, stall_q, stall_d;
  logic wb1_vld_q, wb1_vld_d, wb2_vld_q, wb2_vld_d;
  logic [regWidth-1:0]    wb1_addr_q, wb1_addr_d, wb2_addr_q, wb2_addr_d;
  logic [addressSize-1:0] wb1_data_q, wb1_data_d, wb2_data_q, wb2_data_d;
  logic pop1, pop2, push1, push2;

  always_comb begin
    head_nxt = head_q + ptr_t'(1);
    pop1     = (count_q != '0);
    // Two writes to the same register never retire in the same cycle.
    pop2     = (count_q >= cnt_t'(2)) && (addr_mem[head_nxt] != addr_mem[head_q]);
    // Space is judged on the pre-pop count only.
    push1    = wb.ex1Enable_i && (count_q < cnt_t'(fifoDepth));
    push2    = wb.ex2Enable_i && ((count_q + cnt_t'(push1)) < cnt_t'(fifoDepth));
    wr2_ptr  = tail_q + ptr_t'(push1);

    head_d     = head_q + ptr_t'(pop1) + ptr_t'(pop2);
    tail_d     = tail_q + ptr_t'(push1) + ptr_t'(push2);
    count_d    = count_q + cnt_t'(push1) + cnt_t'(push2) - cnt_t'(pop1) - cnt_t'(pop2);
    overflow_d = overflow_q | (wb.ex1Enable_i & ~push1) | (wb.ex2Enable_i & ~push2);
    stall_d    = (count_d >= cnt_t'(fifoDepth - 1));

    wb1_vld_d  = pop1;
    wb1_addr_d = pop1 ? addr_mem[head_q] : wb1_addr_q;
    wb1_data_d = pop1 ? data_mem[head_q] : wb1_data_q;
    wb2_vld_d  = pop2;
    wb2_addr_d = pop2 ? addr_mem[head_nxt] : wb2_addr_q;
    wb2_data_d = pop2 ? data_mem[head_nxt] : wb2_data_q;
  end

  always_ff @(posedge clock_i) begin
    if (push1) begin
      addr_mem[tail_q] <= wb.ex1Address_i;
      data_mem[tail_q] <= wb.ex1Data_i;
    end
    if (push2) begin
      addr_mem[wr2_ptr] <= wb.ex2Address_i;
      data_mem[wr2_ptr] <= wb.ex2Data_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
      wb1_vld_q  <= 1'b0;
      wb1_addr_q <= '0;
      wb1_data_q <= '0;
      wb2_vld_q  <= 1'b0;
      wb2_addr_q <= '0;
      wb2_data_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
      wb1_vld_q  <= wb1_vld_d;
      wb1_addr_q <= wb1_addr_d;
      wb1_data_q <= wb1_data_d;
      wb2_vld_q  <= wb2_vld_d;
      wb2_addr_q <= wb2_addr_d;
      wb2_data_q <= wb2_data_d;
    end
  end

  assign wb.stall_o                = stall_q;
  assign wb.overflow_o             = overflow_q;
  assign wb.occupancy_o            = count_q;
  assign wb.reg1isWriteback_o      = wb1_vld_q;
  assign wb.reg1WritebackAddress_o = wb1_addr_q;
  assign wb.reg1WritebackData_o    = wb1_data_q;
  assign wb.reg2isWriteback_o      = wb2_vld_q;
  assign wb.reg2WritebackAddress_o = wb2_addr_q;
  assign wb.reg2WritebackData_o    = wb2_data_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_writeback_unit;
  localparam int AW = 64, RW = 5, DEPTH = 8, PW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_unit_if #(.addressSize(AW), .regWidth(RW), .fifoPtrWidth(PW)) wb_if();

  writeback_unit #(.addressSize(AW), .regWidth(RW), .fifoDepth(DEPTH), .fifoPtrWidth(PW)) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .wb      (wb_if)
  );

  typedef struct packed {
    logic [RW-1:0] a;
    logic [AW-1:0] d;
  } ent_t;

  ent_t mq[$];
  logic          m_v1, m_v2, m_ov, m_stall;
  logic [RW-1:0] m_a1, m_a2;
  logic [AW-1:0] m_d1, m_d2;
  int            m_occ;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_v1 = 0; m_v2 = 0; m_ov = 0; m_stall = 0; m_occ = 0;
    m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;
  endtask

  task automatic model_step(input logic e1, input logic [RW-1:0] a1, input logic [AW-1:0] d1,
                            input logic e2, input logic [RW-1:0] a2, input logic [AW-1:0] d2);
    int   c;
    int   np;
    int   npop;
    ent_t e;
    c = mq.size(); np = 0; npop = 0;
    m_v1 = 0; m_v2 = 0;
    if (c >= 1) begin m_v1 = 1; m_a1 = mq[0].a; m_d1 = mq[0].d; npop = 1; end
    if (c >= 2 && mq[1].a != mq[0].a) begin m_v2 = 1; m_a2 = mq[1].a; m_d2 = mq[1].d; npop = 2; end
    if (e1) begin
      if (c + np < DEPTH) begin e.a = a1; e.d = d1; mq.push_back(e); np++; end
      else m_ov = 1;
    end
    if (e2) begin
      if (c + np < DEPTH) begin e.a = a2; e.d = d2; mq.push_back(e); np++; end
      else m_ov = 1;
    end
    repeat (npop) void'(mq.pop_front());
    m_occ = mq.size();
    m_stall = (m_occ >= DEPTH - 1);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_v1"},    wb_if.reg1isWriteback_o, m_v1);
    check_eq({tag, "_a1"},    wb_if.reg1WritebackAddress_o, m_a1);
    check_eq({tag, "_d1"},    wb_if.reg1WritebackData_o, m_d1);
    check_eq({tag, "_v2"},    wb_if.reg2isWriteback_o, m_v2);
    check_eq({tag, "_a2"},    wb_if.reg2WritebackAddress_o, m_a2);
    check_eq({tag, "_d2"},    wb_if.reg2WritebackData_o, m_d2);
    check_eq({tag, "_occ"},   wb_if.occupancy_o, m_occ);
    check_eq({tag, "_stall"}, wb_if.stall_o, m_stall);
    check_eq({tag, "_ovf"},   wb_if.overflow_o, m_ov);
  endtask

  task automatic cycle(input string tag,
                       input logic e1, input logic [RW-1:0] a1, input logic [AW-1:0] d1,
                       input logic e2, input logic [RW-1:0] a2, input logic [AW-1:0] d2);
    wb_if.ex1Enable_i = e1; wb_if.ex1Address_i = a1; wb_if.ex1Data_i = d1;
    wb_if.ex2Enable_i = e2; wb_if.ex2Address_i = a2; wb_if.ex2Data_i = d2;
    @(posedge clk);
    model_step(e1, a1, d1, e2, a2, d2);
    #1;
    wb_if.ex1Enable_i = 0;
    wb_if.ex2Enable_i = 0;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) cycle(tag, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic do_reset();
    #3 rst_n = 0;
    #1;
    check_eq("rst_async_v1",  wb_if.reg1isWriteback_o, 0);
    check_eq("rst_async_v2",  wb_if.reg2isWriteback_o, 0);
    check_eq("rst_async_occ", wb_if.occupancy_o, 0);
    check_eq("rst_async_ovf", wb_if.overflow_o, 0);
    check_eq("rst_async_stl", wb_if.stall_o, 0);
    check_eq("rst_async_a1",  wb_if.reg1WritebackAddress_o, 0);
    check_eq("rst_async_d2",  wb_if.reg2WritebackData_o, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    check_all("rst_rel");
  endtask

  int obs_a[$];
  int sent;
  logic e1r, e2r;

  initial begin
    wb_if.ex1Enable_i = 0; wb_if.ex1Address_i = '0; wb_if.ex1Data_i = '0;
    wb_if.ex2Enable_i = 0; wb_if.ex2Address_i = '0; wb_if.ex2Data_i = '0;
    model_reset();
    #22 rst_n = 1;
    #1 check_all("por");

    // Single push
    cycle("single_push", 1, 5'd5, 64'hAA, 0, '0, '0);
    idle("single_wb", 1);
    check_eq("single_v1", wb_if.reg1isWriteback_o, 1);
    check_eq("single_a1", wb_if.reg1WritebackAddress_o, 5);
    check_eq("single_d1", wb_if.reg1WritebackData_o, 64'hAA);
    check_eq("single_v2", wb_if.reg2isWriteback_o, 0);
    idle("single_after", 1);
    check_eq("single_after_v1", wb_if.reg1isWriteback_o, 0);

    // Dual push, both drained together
    cycle("dual_push", 1, 5'd3, 64'h11, 1, 5'd4, 64'h22);
    idle("dual_wb", 1);
    check_eq("dual_a1", wb_if.reg1WritebackAddress_o, 3);
    check_eq("dual_d1", wb_if.reg1WritebackData_o, 64'h11);
    check_eq("dual_v2", wb_if.reg2isWriteback_o, 1);
    check_eq("dual_a2", wb_if.reg2WritebackAddress_o, 4);
    check_eq("dual_d2", wb_if.reg2WritebackData_o, 64'h22);

    // Same-address pair serialises
    cycle("same_push", 1, 5'd7, 64'h1, 1, 5'd7, 64'h2);
    idle("same_k", 1);
    check_eq("same_k_d1", wb_if.reg1WritebackData_o, 64'h1);
    check_eq("same_k_v2", wb_if.reg2isWriteback_o, 0);
    idle("same_k1", 1);
    check_eq("same_k1_v1", wb_if.reg1isWriteback_o, 1);
    check_eq("same_k1_d1", wb_if.reg1WritebackData_o, 64'h2);
    check_eq("same_k1_v2", wb_if.reg2isWriteback_o, 0);

    // Lone ex2 push, then r0 writeback
    cycle("lone_ex2", 0, '0, '0, 1, 5'd0, 64'hBEEF);
    idle("lone_ex2_wb", 2);

    // Fill and overflow with r9 on both ports
    for (int k = 0; k < 12; k++)
      cycle("fill", 1, 5'd9, 64'(k), 1, 5'd9, 64'(k + 100));
    check_eq("fill_ovf", wb_if.overflow_o, 1);
    idle("fill_drain", 10);

    do_reset();

    // Wrap-around with stall honoured
    sent = 0;
    obs_a.delete();
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (sent < 20 && !m_stall) begin
        cycle("wrap", 1, RW'(sent), 64'h1000 + 64'(sent), 1, RW'(sent + 1), 64'h1000 + 64'(sent + 1));
        sent += 2;
      end else begin
        idle("wrap", 1);
      end
      if (wb_if.reg1isWriteback_o) obs_a.push_back(int'(wb_if.reg1WritebackAddress_o));
      if (wb_if.reg2isWriteback_o) obs_a.push_back(int'(wb_if.reg2WritebackAddress_o));
    end
    check_eq("wrap_count", obs_a.size(), 20);
    for (int i = 0; i < obs_a.size() && i < 20; i++)
      check_eq("wrap_order", obs_a[i], i);
    check_eq("wrap_ovf", wb_if.overflow_o, 0);

    // Random traffic, with an asynchronous reset in the middle
    for (int r = 0; r < 600; r++) begin
      e1r = 1'($urandom_range(0, 1));
      e2r = 1'($urandom_range(0, 1));
      if (m_stall && $urandom_range(0, 3) != 0) begin e1r = 0; e2r = 0; end
      cycle("rand", e1r, RW'($urandom_range(0, 3)), {$urandom, $urandom},
                    e2r, RW'($urandom_range(0, 3)), {$urandom, $urandom});
      if (r == 300) do_reset();
    end
    idle("rand_drain", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Collects execution-unit results and returns them to the register unit's writeback ports.
- Each result is an (address, data) pair. Results are buffered in order in a small FIFO.
- Drains up to two results per cycle onto reg1/reg2 writeback. This clears the register unit's pending-writeback flags and releases stalled reads.
- Sits between the execution units and the register unit, closing the read/mark-pending/writeback loop.

Parameters:
addressSize, 64, width of each writeback data word
regWidth, 5, register address width (32 GPRs)
fifoDepth, 8, buffer entries; must be a power of two, minimum 4
fifoPtrWidth, 3, log2(fifoDepth)

Ports:
clock_i  in  1  clock; all state updates on posedge
reset_i  in  1  asynchronous, active-low reset
ex1Enable_i  in  1  result valid on execution port 1
ex1Address_i  in  regWidth  destination register, port 1
ex1Data_i  in  addressSize  result data, port 1
ex2Enable_i  in  1  result valid on execution port 2
ex2Address_i  in  regWidth  destination register, port 2
ex2Data_i  in  addressSize  result data, port 2
stall_o  out  1  upstream must not present results while high
overflow_o  out  1  sticky: a result was dropped for lack of space
occupancy_o  out  fifoPtrWidth+1  current entry count
reg1isWriteback_o  out  1  writeback 1 valid (single-cycle pulse)
reg1WritebackAddress_o  out  regWidth  writeback 1 register
reg1WritebackData_o  out  addressSize  writeback 1 data
reg2isWriteback_o  out  1  writeback 2 valid (single-cycle pulse)
reg2WritebackAddress_o  out  regWidth  writeback 2 register
reg2WritebackData_o  out  addressSize  writeback 2 data

Behaviour:
- Reset (reset_i low, asynchronous):
  - head/tail pointers, count and all outputs go to 0.
  - Buffer contents are discarded; storage arrays need not be reset.
  - Takes effect immediately, including mid-operation.
- All outputs are registered on posedge. They are therefore stable at the register unit's negedge sample point.
- Pop, evaluated on the pre-edge count C:
  - C = 0: reg1isWriteback_o = reg2isWriteback_o = 0. Address/data outputs hold their previous values.
  - C >= 1: head entry drives reg1 outputs, reg1isWriteback_o = 1.
  - C >= 2 and entry[head+1].address != entry[head].address: entry[head+1] also drives reg2 outputs, reg2isWriteback_o = 1. Otherwise reg2isWriteback_o = 0.
    - This same-address rule keeps two writes to one register from landing in the same cycle.
  - The head pointer advances by the number of entries popped (0, 1 or 2), with modulo-fifoDepth wrap.
- Push, same edge:
  - Order is ex1 first, then ex2. Either port may push alone; a lone ex2 takes the tail slot.
  - A push is accepted only if C + (pushes accepted so far this cycle) < fifoDepth. Space is judged on the pre-pop count, so a pop never frees space in the same cycle.
  - A refused push is dropped and sets overflow_o = 1; it stays set until reset.
  - The tail pointer advances with modulo wrap.
- Count update: count_next = C + pushes − pops.
  - occupancy_o = count_next (registered).
  - stall_o = (count_next >= fifoDepth − 1), so upstream always has at least two free slots when stall_o is low.
- Latency: a result sampled at edge N reaches the writeback outputs after edge N+1, provided no older entries are ahead of it. There is no bypass path.
- Ordering:
  - Results are written back strictly in FIFO order.
  - The reg1 slot is always older than the reg2 slot in the same cycle.
- No restriction on register 0: writebacks to r0 are issued like any other address.

Test Plan:
- Reset: hold reset_i = 0 during activity -> all outputs 0 immediately. After release, occupancy_o = 0, stall_o = 0, overflow_o = 0.
- Single push: ex1 r5 / 0x00000000000000AA at edge N -> after edge N+1, reg1isWriteback_o = 1, address 5, data 0xAA, reg2isWriteback_o = 0. At edge N+2, both valids = 0.
- Dual push: ex1 r3 / 0x11, ex2 r4 / 0x22 on the same edge -> one cycle later reg1 = r3 / 0x11 and reg2 = r4 / 0x22, both valid together.
- Same-address pair: ex1 r7 / 0x1, ex2 r7 / 0x2 -> cycle k: reg1 = r7 / 0x1 only. Cycle k+1: reg1 = r7 / 0x2. reg2isWriteback_o = 0 in both cycles.
- Fill/overflow (depth 8): push r9 on both ports every cycle -> occupancy_o rises by 1 per cycle. stall_o asserts at occupancy 7. Pushing on regardless -> overflow_o = 1 and the dropped data never appears on the writeback outputs.
- Wrap-around: stream 20 distinct-address results across both ports with stall honoured -> all 20 appear exactly once, in push order, with no loss and overflow_o = 0.
